uart_tx_sequencer: RTL and testbench

Transmit-side controller for the UART baud generator. It accepts one data word per valid/ready handshake and gates the generator through BaudEn_o. It then advances the serial line one bit per BaudSig_i pulse: start, data LSB-first, optional parity, then 1 or 2 stop bits. It sits between the host byte interface and the pad-side Tx pin, and is the only owner of the generator enable on the TX path.

---
 rtl/uart_pkg.sv | 37 +++
 rtl/uart_tx_sequencer_if.sv | 14 +
 rtl/uart_tx_sequencer.sv | 163 ++++++++++++++++
 tb/tb_uart_tx_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: sequencer state encoding, frame configuration
// encodings, legal data-width range and the frame parity helper.
package uart_pkg;

    // Sequencer states; three bits, binary encoded.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP1  = 3'd4,
        ST_STOP2  = 3'd5
    } uart_state_t;

    // Encodings of the parity-select and stop-bit-select inputs.
    typedef enum logic {
        PARITY_EVEN = 1'b0,
        PARITY_ODD  = 1'b1
    } parity_sel_t;

    typedef enum logic {
        STOP_ONE = 1'b0,
        STOP_TWO = 1'b1
    } stop_sel_t;

    // Legal number of data bits per frame, shared by the TX and RX sequencers.
    localparam int DATA_BITS_MIN = 5;
    localparam int DATA_BITS_MAX = 8;

    // Parity bit for a zero-extended data word: even parity is the XOR of
    // the data bits, odd parity is its inverse.
    function automatic logic frame_parity(input logic [DATA_BITS_MAX-1:0] data,
                                          input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_sequencer_if.sv
// Host byte interface of the UART transmit sequencer: one word per
// valid/ready handshake.
interface uart_tx_sequencer_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_MAX
);
    logic [DATA_BITS-1:0] TxData_i;
    logic                 TxValid_i;
    logic                 TxReady_o;

    modport master (output TxData_i, output TxValid_i, input TxReady_o);
    modport slave  (input TxData_i, input TxValid_i, output TxReady_o);
endinterface

// File: rtl/uart_tx_sequencer.sv
// UART transmit sequencer: takes one word per handshake, enables the baud
// generator and steps the serial line one bit per BaudSig_i pulse through
// start, data (LSB first), optional parity and one or two stop bits.
module uart_tx_sequencer
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8
)
(
    input  logic                clk,
    input  logic                rst,
    uart_tx_sequencer_if.slave  host,
    input  logic                ParityEn_i,
    input  logic                ParityOdd_i,
    input  logic                StopBits_i,
    input  logic                Abort_i,
    input  logic                BaudSig_i,
    output logic                BaudEn_o,
    output logic                Tx_o,
    output logic                TxBusy_o,
    output logic                TxDone_o
);

    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_data_bits
        $error("uart_tx_sequencer: DATA_BITS out of range");
    end

    uart_state_t              state_q, state_d;
    logic [DATA_BITS-1:0]     shift_q, shift_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic                     par_en_q, par_en_d;
    logic                     par_q, par_d;
    logic                     stop2_q, stop2_d;
    logic                     tx_q, tx_d;
    logic                     baud_en_q, baud_en_d;
    logic                     ready_q, ready_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic [DATA_BITS_MAX-1:0] data_ext;

    assign data_ext = DATA_BITS_MAX'(host.TxData_i);

    // Next state, datapath updates and the next value of every registered output.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        par_en_d = par_en_q;
        par_d    = par_q;
        stop2_d  = stop2_q;
        done_d   = 1'b0;

        if (state_q != ST_IDLE && Abort_i) begin
            // Abort wins over a coincident BaudSig_i and drops the word.
            state_d = ST_IDLE;
            shift_d = '0;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (host.TxValid_i && ready_q && !Abort_i) begin
                        shift_d  = host.TxData_i;
                        idx_d    = '0;
                        par_en_d = ParityEn_i;
                        par_d    = frame_parity(data_ext, ParityOdd_i == PARITY_ODD);
                        stop2_d  = (StopBits_i == STOP_TWO);
                        state_d  = ST_START;
                    end
                end
                ST_START: begin
                    if (BaudSig_i) begin
                        idx_d   = '0;
                        state_d = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (BaudSig_i) begin
                        if (idx_q == LAST_IDX) begin
                            state_d = par_en_q ? ST_PARITY : ST_STOP1;
                        end else begin
                            shift_d = shift_q >> 1;
                            idx_d   = idx_q + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (BaudSig_i) begin
                        state_d = ST_STOP1;
                    end
                end
                ST_STOP1: begin
                    if (BaudSig_i) begin
                        if (stop2_q) begin
                            state_d = ST_STOP2;
                        end else begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
                ST_STOP2: begin
                    if (BaudSig_i) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Outputs are registered, so they follow the state being entered.
        unique case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = par_d;
            default:   tx_d = 1'b1;
        endcase
        baud_en_d = (state_d != ST_IDLE);
        busy_d    = (state_d != ST_IDLE);
        ready_d   = (state_d == ST_IDLE);
    end

    // State, frame registers and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            idx_q     <= '0;
            par_en_q  <= 1'b0;
            par_q     <= 1'b0;
            stop2_q   <= 1'b0;
            tx_q      <= 1'b1;
            baud_en_q <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            idx_q     <= idx_d;
            par_en_q  <= par_en_d;
            par_q     <= par_d;
            stop2_q   <= stop2_d;
            tx_q      <= tx_d;
            baud_en_q <= baud_en_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign host.TxReady_o = ready_q;
    assign BaudEn_o       = baud_en_q;
    assign Tx_o           = tx_q;
    assign TxBusy_o       = busy_q;
    assign TxDone_o       = done_q;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Directed bench for uart_tx_sequencer: table of frames with hand-computed
// serial bit patterns, plus back-to-back, abort and reset sequences.
module tb_uart_tx_sequencer;

    localparam int BAUD_N = 16;

    logic clk;
    logic rst;
    logic ParityEn, ParityOdd, StopBits, Abort, BaudSig;
    logic BaudEn, Tx, Busy, Done;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx_sequencer_if #(.DATA_BITS(8)) host_if ();

    uart_tx_sequencer #(.DATA_BITS(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .host        (host_if.slave),
        .ParityEn_i  (ParityEn),
        .ParityOdd_i (ParityOdd),
        .StopBits_i  (StopBits),
        .Abort_i     (Abort),
        .BaudSig_i   (BaudSig),
        .BaudEn_o    (BaudEn),
        .Tx_o        (Tx),
        .TxBusy_o    (Busy),
        .TxDone_o    (Done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame record: bits[i] is the line level of bit period i (0 = start bit).
    typedef struct {
        logic [7:0]  data;
        logic        pen;
        logic        podd;
        logic        stop2;
        logic [11:0] bits;
        int          nbits;
    } vec_t;

    vec_t vecs[6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Offer one word, then scramble data/config to show they are latched.
    task automatic accept(input logic [7:0] data, input logic pen, input logic podd,
                          input logic stop2);
        int waited = 0;
        while (host_if.TxReady_o !== 1'b1 && waited < 100) begin
            step();
            waited++;
        end
        check("ready_before_accept", host_if.TxReady_o, 1);
        host_if.TxData_i  = data;
        host_if.TxValid_i = 1'b1;
        ParityEn  = pen;
        ParityOdd = podd;
        StopBits  = stop2;
        step();
        host_if.TxValid_i = 1'b0;
        host_if.TxData_i  = ~data;
        ParityEn  = ~pen;
        ParityOdd = ~podd;
        StopBits  = ~stop2;
        check("start_tx", Tx, 0);
        check("start_baud_en", BaudEn, 1);
        check("start_busy", Busy, 1);
        check("start_ready", host_if.TxReady_o, 0);
    endtask

    // Drive bit periods [first, last) with a BaudSig pulse closing each one.
    task automatic play_periods(input logic [11:0] bits, input int first, input int last);
        for (int b = first; b < last; b++) begin
            for (int c = 0; c < BAUD_N; c++) begin
                BaudSig = (c == BAUD_N - 1);
                if (c == BAUD_N / 2) begin
                    check($sformatf("tx_bit%0d", b), Tx, bits[b]);
                    check("baud_en_in_frame", BaudEn, 1);
                    check("done_in_frame", Done, 0);
                end
                step();
            end
        end
        BaudSig = 1'b0;
    endtask

    // State right after the final stop-bit pulse.
    task automatic check_finish();
        check("finish_done", Done, 1);
        check("finish_baud_en", BaudEn, 0);
        check("finish_busy", Busy, 0);
        check("finish_ready", host_if.TxReady_o, 1);
        check("finish_tx", Tx, 1);
    endtask

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 12'b0011_0100_1010, 10};
        vecs[1] = '{8'h07, 1'b1, 1'b0, 1'b0, 12'b0110_0000_1110, 11};
        vecs[2] = '{8'h07, 1'b1, 1'b1, 1'b0, 12'b0100_0000_1110, 11};
        vecs[3] = '{8'h3C, 1'b1, 1'b0, 1'b1, 12'b1100_0111_1000, 12};
        vecs[4] = '{8'h00, 1'b1, 1'b1, 1'b0, 12'b0110_0000_0000, 11};
        vecs[5] = '{8'hFF, 1'b0, 1'b0, 1'b1, 12'b0111_1111_1110, 11};

        rst = 1'b0;
        host_if.TxData_i  = '0;
        host_if.TxValid_i = 1'b0;
        ParityEn = 0; ParityOdd = 0; StopBits = 0; Abort = 0; BaudSig = 0;
        #23;
        check("reset_tx", Tx, 1);
        check("reset_baud_en", BaudEn, 0);
        check("reset_ready", host_if.TxReady_o, 1);
        check("reset_busy", Busy, 0);
        check("reset_done", Done, 0);
        @(negedge clk);
        rst = 1'b1;
        step();

        // Table of single frames.
        for (int i = 0; i < 6; i++) begin
            accept(vecs[i].data, vecs[i].pen, vecs[i].podd, vecs[i].stop2);
            play_periods(vecs[i].bits, 0, vecs[i].nbits);
            check_finish();
            step();
            check("done_single_pulse", Done, 0);
            step();
        end

        // Back-to-back: valid held high, second word taken in the done cycle.
        host_if.TxData_i  = 8'h55;
        host_if.TxValid_i = 1'b1;
        ParityEn = 0; ParityOdd = 0; StopBits = 0;
        step();
        host_if.TxData_i = 8'hAA;
        check("b2b_first_start", BaudEn, 1);
        play_periods(12'b0010_1010_1010, 0, 10);
        check_finish();
        step();
        host_if.TxValid_i = 1'b0;
        check("b2b_second_baud_en", BaudEn, 1);
        check("b2b_second_start_tx", Tx, 0);
        check("b2b_second_done_low", Done, 0);
        play_periods(12'b0011_0101_0100, 0, 10);
        check_finish();
        step();

        // Abort in IDLE blocks the accept for that cycle only.
        host_if.TxData_i  = 8'hA5;
        host_if.TxValid_i = 1'b1;
        Abort = 1'b1;
        step();
        check("idle_abort_baud_en", BaudEn, 0);
        check("idle_abort_ready", host_if.TxReady_o, 1);
        Abort = 1'b0;
        step();
        host_if.TxValid_i = 1'b0;
        check("after_idle_abort_start", BaudEn, 1);
        play_periods(vecs[0].bits, 0, 10);
        check_finish();
        step();

        // Abort during data bit 3, coincident with BaudSig.
        accept(8'hA5, 1'b0, 1'b0, 1'b0);
        play_periods(vecs[0].bits, 0, 4);
        for (int c = 0; c < BAUD_N - 1; c++) begin
            if (c == BAUD_N / 2) check("abort_pre_bit3", Tx, vecs[0].bits[4]);
            step();
        end
        BaudSig = 1'b1;
        Abort   = 1'b1;
        step();
        BaudSig = 1'b0;
        Abort   = 1'b0;
        check("abort_tx", Tx, 1);
        check("abort_baud_en", BaudEn, 0);
        check("abort_ready", host_if.TxReady_o, 1);
        check("abort_busy", Busy, 0);
        begin
            logic seen_done = 1'b0;
            for (int c = 0; c < 20; c++) begin
                if (Done) seen_done = 1'b1;
                step();
            end
            check("abort_no_done", seen_done, 0);
        end
        accept(vecs[3].data, vecs[3].pen, vecs[3].podd, vecs[3].stop2);
        play_periods(vecs[3].bits, 0, vecs[3].nbits);
        check_finish();
        step();

        // Asynchronous reset in the middle of STOP1.
        accept(8'hA5, 1'b0, 1'b0, 1'b0);
        play_periods(vecs[0].bits, 0, 9);
        step();
        step();
        check("pre_reset_busy", Busy, 1);
        #3;
        rst = 1'b0;
        #1;
        check("async_reset_tx", Tx, 1);
        check("async_reset_baud_en", BaudEn, 0);
        check("async_reset_ready", host_if.TxReady_o, 1);
        check("async_reset_busy", Busy, 0);
        check("async_reset_done", Done, 0);
        step();
        step();
        @(negedge clk);
        rst = 1'b1;
        step();
        for (int k = 0; k < 6; k++) begin
            BaudSig = 1'b1;
            step();
            BaudSig = 1'b0;
            check("idle_baud_tx", Tx, 1);
            check("idle_baud_en", BaudEn, 0);
            check("idle_baud_busy", Busy, 0);
            check("idle_baud_done", Done, 0);
            step();
        end
        accept(vecs[1].data, vecs[1].pen, vecs[1].podd, vecs[1].stop2);
        play_periods(vecs[1].bits, 0, vecs[1].nbits);
        check_finish();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
